// File: rtl/apb_timer.sv
// APB timer/compare peripheral: 8-bit prescaler feeding a 32-bit up-counter that
// restarts on compare match, with periodic/one-shot modes and a sticky match interrupt.
module apb_timer #(
    parameter int ADRW = 12
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            psel,
    input  logic            penable,
    input  logic [ADRW-1:0] paddr,
    input  logic            pwrite,
    input  logic [31:0]     pwdata,
    output logic [31:0]     prdata,
    output logic            pready,
    output logic            irq
);

    localparam logic [ADRW-3:0] W_CTRL   = (ADRW-2)'(0);
    localparam logic [ADRW-3:0] W_COUNT  = (ADRW-2)'(1);
    localparam logic [ADRW-3:0] W_CMP    = (ADRW-2)'(2);
    localparam logic [ADRW-3:0] W_STATUS = (ADRW-2)'(3);

    logic        r_en;
    logic        r_oneshot;
    logic        r_irqen;
    logic [7:0]  r_presc;
    logic [7:0]  r_pcnt;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_match;

    logic            w_acc;
    logic            w_wr;
    logic            w_rd;
    logic [ADRW-3:0] w_word;
    logic            w_wr_ctrl;
    logic            w_wr_count;
    logic            w_wr_cmp;
    logic            w_wr_status;
    logic            w_tick;
    logic            w_hit;
    logic            w_unused;

    assign w_acc       = psel & penable;
    assign w_wr        = w_acc & pwrite;
    assign w_rd        = w_acc & ~pwrite;
    assign w_word      = paddr[ADRW-1:2];
    assign w_unused    = ^paddr[1:0];

    assign w_wr_ctrl   = w_wr & (w_word == W_CTRL);
    assign w_wr_count  = w_wr & (w_word == W_COUNT);
    assign w_wr_cmp    = w_wr & (w_word == W_CMP);
    assign w_wr_status = w_wr & (w_word == W_STATUS);

    // A COUNT write in the same cycle suppresses the match; compare uses the pre-edge CMP.
    assign w_tick      = r_en & (r_pcnt == r_presc);
    assign w_hit       = w_tick & (r_count == r_cmp) & ~w_wr_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_en      <= 1'b0;
            r_oneshot <= 1'b0;
            r_irqen   <= 1'b0;
            r_presc   <= '0;
        end else if (w_wr_ctrl) begin
            r_en      <= pwdata[0];
            r_oneshot <= pwdata[1];
            r_irqen   <= pwdata[2];
            r_presc   <= pwdata[15:8];
        end else if (w_hit & r_oneshot) begin
            r_en      <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset || w_wr_ctrl || !r_en || w_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= pwdata;
        end else if (w_hit) begin
            r_count <= '0;
        end else if (w_tick) begin
            r_count <= r_count + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cmp <= '0;
        end else if (w_wr_cmp) begin
            r_cmp <= pwdata;
        end
    end

    // Set has priority over a simultaneous write-1-to-clear.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_match <= 1'b0;
        end else if (w_hit) begin
            r_match <= 1'b1;
        end else if (w_wr_status & pwdata[0]) begin
            r_match <= 1'b0;
        end
    end

    always_comb begin
        prdata = '0;
        if (w_rd) begin
            case (w_word)
                W_CTRL:   prdata = {16'h0, r_presc, 5'h0, r_irqen, r_oneshot, r_en};
                W_COUNT:  prdata = r_count;
                W_CMP:    prdata = r_cmp;
                W_STATUS: prdata = {31'h0, r_match};
                default:  prdata = '0;
            endcase
        end
    end

    assign pready = 1'b1;
    assign irq    = r_match & r_irqen;

endmodule

// File: doc/apb_timer.md
# apb_timer

Programmable 32-bit timer/compare peripheral on one of the APB slave ports driven by the AXI-to-APB bridge. Internal 8-bit prescaler and a 32-bit up-counter that restarts on compare match. Supports periodic and one-shot modes. Raises a level interrupt from a sticky match flag. Registers are CPU-accessible through the single-cycle APB access the bridge generates.

## Interface
- ADRW, 12, APB address width (byte address; `paddr[ADRW-1:2]` selects word, `paddr[1:0]` ignored)
- aclk  in  1  clock
- areset  in  1  reset; synchronous, active-high
- psel  in  1  slave select
- penable  in  1  access enable (asserted in same cycle as psel, no separate setup phase)
- paddr  in  ADRW  byte address within slave window
- pwrite  in  1  1 = write, 0 = read
- pwdata  in  32  write data
- prdata  out  32  read data, combinational
- pready  out  1  transfer ready; constant 1
- irq  out  1  interrupt, level, active-high

## Operation
- Access = psel & penable. Write commits at the clock edge ending the access cycle. Read data is valid combinationally in the access cycle.
- prdata = 0 when no read access is in progress.
- Register map (byte offsets):
  - 0x000 CTRL (rw): bit0 EN, bit1 ONESHOT, bit2 IRQEN, bits[15:8] PRESC. Other bits read 0.
  - 0x004 COUNT (rw): current counter value.
  - 0x008 CMP (rw): compare value.
  - 0x00C STATUS: bit0 MATCH. Read gives the sticky flag. Write 1 to bit0 clears it. Writing 0 has no effect.
  - Any other offset: reads 0, writes ignored.
- Prescaler: internal 8-bit pcnt.
  - While EN=1, pcnt increments each cycle.
  - When pcnt==PRESC, the cycle is a tick and pcnt←0.
  - EN=0 holds pcnt at 0. Any CTRL write sets pcnt←0.
- Counter: on a tick,
  - If COUNT==CMP: COUNT←0 and MATCH←1. If ONESHOT=1, also EN←0.
  - Otherwise: COUNT←COUNT+1, 32-bit modulo. From 0xFFFFFFFF it wraps to 0, with no match generated at the wrap.
- Periodic match interval = (PRESC+1)·(CMP+1) cycles.
- irq = MATCH & IRQEN. Combinational from registers, no extra delay.
- Simultaneous events, priority:
  - APB write to COUNT in a tick cycle: the write wins (no increment, no match that cycle).
  - APB write to CTRL in a cycle where one-shot would clear EN: the written EN wins.
  - W1C to STATUS in a cycle where a match sets MATCH: the set wins (MATCH stays 1).
  - Write to CMP in a tick cycle: the compare uses the old CMP. The new CMP applies from the next tick.
- Reset (any cycle, including mid-count): CTRL=0, COUNT=0, CMP=0, STATUS=0, pcnt=0. Outputs: irq=0, prdata=0, pready=1.

## Timing
- Write latency: register value is visible one cycle after the access cycle, for both reads and counter behaviour.
- Read latency: 0. prdata reflects pre-edge register state in the access cycle.
- The bridge samples prdata in its READ cycle and requires pready=1 there. pready is never deasserted, so the bridge's WRITE and READ states each last exactly one cycle.
- First tick after an EN 0→1 write: PRESC+1 cycles after the write edge.
- With PRESC=0, a tick occurs every enabled cycle.
- MATCH and irq rise on the edge of the matching tick.
- In one-shot mode EN clears on that same edge, so COUNT stays 0 afterwards.

## Test plan
- Reset mid-count: enabled timer, COUNT=0x10, MATCH=1, assert areset for one cycle → all registers read 0, irq=0, counting stops.
- Periodic: CMP=3, PRESC=1, CTRL=0x5 (EN, IRQEN) → MATCH/irq rise every 8 cycles. COUNT sequence 0,0,1,1,2,2,3,3,0. W1C 0x1 to STATUS drops irq on the next cycle.
- One-shot: CMP=2, PRESC=0, CTRL=0x3 → exactly one match 3 cycles after enable. EN reads 0 and COUNT stays 0. irq stays 0 because IRQEN=0.
- Wrap: CMP=5, write COUNT=0xFFFFFFFE, PRESC=0, EN=1 → COUNT goes 0xFFFFFFFF, 0, …, 5, then match. No MATCH at the wrap.
- Collisions:
  - Write COUNT=0x100 in a tick cycle where COUNT==CMP → COUNT reads 0x100 and MATCH stays 0.
  - W1C STATUS in a match cycle → MATCH reads 1.
- Decode: read offsets 0x010 and 0xFFC → 0. Write 0xFFFFFFFF to CTRL → reads 0x0000FF07. Every access sees pready=1.
